spi_bus_sequencer: RTL and testbench
====================================

Name: spi_bus_sequencer

Overview:
- Master-side controller that shares one SPI bus between NREQ on-chip requesters and runs 8-bit full-duplex transfers to up to NSLV slave devices.
- Each slave uses the team's SPI slave protocol:
  - CS falling edge loads the slave's transmit byte.
  - The slave samples MOSI on rising SCLK.
  - The slave's counter captures exactly 8 rising edges while CS is low.
- The block arbitrates round-robin, drives one-hot active-low chip selects, shifts MOSI/MISO, and returns the received byte to the winning requester.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NSLV, 4, number of slave chip selects (1..8).
- SW, 2, slave-index width; must satisfy 2^SW >= NSLV.

Ports:
- reset  in  1  asynchronous, active-high reset.
- SCLK  in  1  clock; all block state updates on the falling edge of SCLK.
- req  in  NREQ  per-requester transfer request; held high until that requester's done bit pulses.
- req_slv  in  NREQ*SW  packed slave index per requester; requester i uses bits [i*SW +: SW].
- req_data  in  NREQ*8  packed transmit byte per requester.
- grant  out  NREQ  one-hot; set for the whole transfer, including the GAP cycle.
- done  out  NREQ  one-hot, one-cycle pulse at transfer end.
- rx_data  out  8  last received byte; held until the next transfer ends.
- err  out  1  asserted with done when the granted slave index is >= NSLV.
- busy  out  1  high in XFER and GAP.
- cs_n  out  NSLV  active-low chip selects; at most one is low.
- MOSI  out  1  serial data out; equals shreg[7] in XFER, otherwise 0.
- MISO  in  1  serial data in; may be Z when no slave is selected.

Behaviour:
- Reset values, applied immediately: state IDLE; cs_n all 1; grant, done, err, busy = 0; rx_data 0; shreg 0; bitcnt 0; RR pointer 0.
- Reset mid-transfer aborts the transfer: CS releases at once and no done pulse is issued.
- IDLE:
  - At a falling edge with any req high, the round-robin arbiter picks the first requester at or after the pointer.
  - Latch shreg <= req_data[w] and slv <= req_slv[w]; set grant[w]; pointer <= w+1 (mod NREQ).
  - Valid slv: cs_n[slv] <= 0, bitcnt <= 0, go to XFER. The slave then presents its bit7 on MISO and the master presents its bit7 on MOSI before the first rising edge.
  - slv >= NSLV: no CS asserted; go directly to GAP with err pending.
- XFER, at each falling edge:
  - shreg <= {shreg[6:0], MISO}; bitcnt++.
  - After the 8th falling edge (bitcnt reaches 8), the following happen together:
    - cs_n returns to all 1;
    - rx_data <= the final shreg value;
    - state moves to GAP.
  - CS is therefore high before the 9th rising edge, so the slave captures exactly 8 bits.
- Resulting bit alignment:
  - MISO sampled on falling edge k carries slave bit (8-k).
  - MOSI after falling edge k carries master bit (7-k).
- GAP (one cycle):
  - cs_n all high; done[w] = 1 and err valid for this cycle only.
  - Next falling edge: grant clears, state returns to IDLE.
  - Guarantees at least one full SCLK period with CS high between transfers, so the slave sees a fresh CS falling edge.
- Throughput and latency:
  - 10 falling edges per transfer: grant, 8 bits, GAP.
  - Minimum gap between back-to-back transfers: 1 IDLE cycle.
- Requester rules:
  - req deasserting during XFER is ignored; the transfer completes.
  - A requester still holding req in IDLE after its done is re-arbitrated normally.
- Simultaneous requests are resolved purely by the RR pointer; there is no fixed priority.

Decomposition:
- Package spi_seq_pkg holds:
  - state encoding (IDLE, XFER, GAP);
  - WORD_W = 8;
  - BITCNT_W = 4.
- One sub-module, spi_rr_arbiter:
  - inputs: req vector, pointer;
  - outputs: one-hot winner, valid;
  - purely combinational.
- FSM, shift register and CS decode stay in spi_bus_sequencer.

Test Plan:
1. req[0], slv=1, data 8'hA5; slave 1 loaded with 8'h3C.
   - cs_n=4'b1101 for exactly 8 SCLK periods.
   - Slave receives 8'hA5; rx_data=8'h3C; done=4'b0001 one cycle; err=0.
2. All four req high after reset with distinct data.
   - Grants in order 0,1,2,3.
   - Each done carries the matching slave byte; cs_n high for ≥1 period between transfers.
3. req[1] and req[3] held continuously.
   - Grants alternate 1,3,1,3; no starvation over 8 transfers.
4. Reset asserted after 4 bits of a transfer to slave 2.
   - cs_n=4'b1111, busy=0, no done.
   - After release, a new transfer 8'h5A to slave 2 completes with correct rx_data.
5. NSLV=3, req[2] with slv=3.
   - cs_n stays 3'b111; done[2] and err=1 in the cycle after grant; rx_data unchanged.
6. Back-to-back transfers to the same slave with slave data 8'hF0 then 8'h0F.
   - Second rx_data=8'h0F, proving the slave reload on a fresh CS falling edge.

Source files
------------

// File: rtl/spi_seq_pkg.sv
// rtl/spi_seq_pkg.sv - shared types and widths for the SPI bus sequencer
package spi_seq_pkg;

    localparam int WORD_W   = 8;
    localparam int BITCNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/spi_rr_arbiter.sv
// rtl/spi_rr_arbiter.sv - combinational round-robin pick, first request at or after ptr
module spi_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] winner,
    output logic            valid
);

    logic [PW-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = PW'((int'(ptr) + i) % NREQ);
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_bus_sequencer.sv
// rtl/spi_bus_sequencer.sv - shares one SPI bus between requesters, 8-bit full-duplex transfers
module spi_bus_sequencer
    import spi_seq_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int NSLV = 4,
    parameter int SW   = 2
) (
    input  logic                   reset,
    input  logic                   SCLK,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*SW-1:0]     req_slv,
    input  logic [NREQ*WORD_W-1:0] req_data,
    output logic [NREQ-1:0]        grant,
    output logic [NREQ-1:0]        done,
    output logic [WORD_W-1:0]      rx_data,
    output logic                   err,
    output logic                   busy,
    output logic [NSLV-1:0]        cs_n,
    output logic                   MOSI,
    input  logic                   MISO
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t                state_q, state_d;
    logic [WORD_W-1:0]     shreg_q, shreg_d;
    logic [BITCNT_W-1:0]   bitcnt_q, bitcnt_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [NREQ-1:0]       grant_q, grant_d;
    logic [NREQ-1:0]       done_q, done_d;
    logic                  err_q, err_d;
    logic [WORD_W-1:0]     rx_data_q, rx_data_d;
    logic [NSLV-1:0]       cs_n_q, cs_n_d;

    logic [NREQ-1:0]       arb_winner;
    logic                  arb_valid;
    logic [WORD_W-1:0]     sel_data;
    logic [SW-1:0]         sel_slv;
    logic [PW-1:0]         sel_next_ptr;
    logic                  slv_ok;

    spi_rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req    (req),
        .ptr    (ptr_q),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

    // Route the winner's byte and slave index, and the pointer slot just past it.
    always_comb begin
        sel_data     = '0;
        sel_slv      = '0;
        sel_next_ptr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_winner[i]) begin
                sel_data     = req_data[i*WORD_W +: WORD_W];
                sel_slv      = req_slv[i*SW +: SW];
                sel_next_ptr = (i == NREQ - 1) ? '0 : PW'(i + 1);
            end
        end
        slv_ok = (int'(sel_slv) < NSLV);
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        done_d    = '0;
        err_d     = 1'b0;
        rx_data_d = rx_data_q;
        cs_n_d    = cs_n_q;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    shreg_d  = sel_data;
                    grant_d  = arb_winner;
                    ptr_d    = sel_next_ptr;
                    bitcnt_d = '0;
                    if (slv_ok) begin
                        for (int s = 0; s < NSLV; s++) begin
                            if (sel_slv == SW'(s)) begin
                                cs_n_d[s] = 1'b0;
                            end
                        end
                        state_d = XFER;
                    end else begin
                        // Nothing to talk to: report the bad index in a normal GAP cycle.
                        done_d  = arb_winner;
                        err_d   = 1'b1;
                        state_d = GAP;
                    end
                end
            end
            XFER: begin
                shreg_d  = {shreg_q[WORD_W-2:0], MISO};
                bitcnt_d = bitcnt_q + BITCNT_W'(1);
                // Raise CS on the 8th falling edge so the slave never sees a 9th rising edge.
                if (bitcnt_d == BITCNT_W'(WORD_W)) begin
                    cs_n_d    = '1;
                    rx_data_d = shreg_d;
                    done_d    = grant_q;
                    state_d   = GAP;
                end
            end
            GAP: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(negedge SCLK or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            ptr_q     <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            rx_data_q <= '0;
            cs_n_q    <= '1;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rx_data_q <= rx_data_d;
            cs_n_q    <= cs_n_d;
        end
    end

    assign grant   = grant_q;
    assign done    = done_q;
    assign err     = err_q;
    assign rx_data = rx_data_q;
    assign cs_n    = cs_n_q;
    assign busy    = (state_q != IDLE);
    assign MOSI    = (state_q == XFER) ? shreg_q[WORD_W-1] : 1'b0;

endmodule

// File: tb/tb_spi_bus_sequencer.sv
// tb/tb_spi_bus_sequencer.sv - directed and randomized checks of spi_bus_sequencer against a transfer-level model
module tb_spi_bus_sequencer;

    localparam int NREQ = 4;
    localparam int NSLV = 3;
    localparam int SW   = 2;
    localparam logic [31:0] CS_IDLE = 32'((1 << NSLV) - 1);

    logic                SCLK = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req;
    logic [NREQ*SW-1:0]  req_slv;
    logic [NREQ*8-1:0]   req_data;
    logic [NREQ-1:0]     grant;
    logic [NREQ-1:0]     done;
    logic [7:0]          rx_data;
    logic                err;
    logic                busy;
    logic [NSLV-1:0]     cs_n;
    logic                MOSI;
    logic                MISO;

    int total = 0;
    int bad   = 0;
    int ptr   = 0;
    logic [7:0] rx_exp = 8'h00;

    logic [7:0] slv_tx  [NSLV];
    logic [7:0] slv_sh  [NSLV];
    logic [7:0] slv_rx  [NSLV];
    int         slv_cnt [NSLV];
    bit         slv_act [NSLV];

    always #5 SCLK = ~SCLK;

    spi_bus_sequencer #(
        .NREQ (NREQ),
        .NSLV (NSLV),
        .SW   (SW)
    ) dut (
        .reset    (reset),
        .SCLK     (SCLK),
        .req      (req),
        .req_slv  (req_slv),
        .req_data (req_data),
        .grant    (grant),
        .done     (done),
        .rx_data  (rx_data),
        .err      (err),
        .busy     (busy),
        .cs_n     (cs_n),
        .MOSI     (MOSI),
        .MISO     (MISO)
    );

    // Slave devices: load on the first rising edge of a fresh CS-low window,
    // sample MOSI on rising edges, advance MISO on falling edges.
    always @(posedge SCLK or negedge SCLK) begin
        for (int s = 0; s < NSLV; s++) begin
            if (SCLK) begin
                if (!cs_n[s]) begin
                    if (!slv_act[s]) begin
                        slv_act[s] <= 1'b1;
                        slv_sh[s]  <= slv_tx[s];
                        slv_cnt[s] <= 1;
                        slv_rx[s]  <= {7'b0, MOSI};
                    end else begin
                        slv_cnt[s] <= slv_cnt[s] + 1;
                        slv_rx[s]  <= {slv_rx[s][6:0], MOSI};
                    end
                end else begin
                    slv_act[s] <= 1'b0;
                end
            end else if (slv_act[s] && !cs_n[s]) begin
                slv_sh[s] <= {slv_sh[s][6:0], 1'b0};
            end
        end
    end

    always_comb begin
        MISO = 1'bz;
        for (int s = 0; s < NSLV; s++) begin
            if (!cs_n[s]) MISO = slv_sh[s][7];
        end
    end

    task automatic cyc();
        @(posedge SCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        int idx;
        for (int k = 0; k < NREQ; k++) begin
            idx = (p + k) % NREQ;
            if (r[idx[1:0]]) return idx;
        end
        return 0;
    endfunction

    // One whole transfer: expected winner, bus activity, result and the idle cycle after it.
    task automatic xfer(input bit drop);
        int         w;
        int         n;
        int         lows;
        logic [1:0] sidx;
        logic [7:0] mdata;
        logic [7:0] sdata;
        bit         ok_slv;
        w      = rr_pick(req, ptr);
        sidx   = req_slv[w*SW +: SW];
        mdata  = req_data[w*8 +: 8];
        ok_slv = (int'(sidx) < NSLV);
        sdata  = ok_slv ? slv_tx[sidx] : 8'h00;

        n = 0;
        while (grant == '0 && n < 12) begin
            cyc();
            n++;
        end
        chk("grant", 32'(grant), 32'(1 << w));
        chk("cs_select", 32'(cs_n), ok_slv ? (CS_IDLE & ~(32'(1) << sidx)) : CS_IDLE);
        chk("mosi_bit7", 32'(MOSI), ok_slv ? 32'(mdata[7]) : 32'(0));

        lows = 0;
        n    = 0;
        while (done == '0 && n < 12) begin
            if (32'(cs_n) != CS_IDLE) lows++;
            cyc();
            n++;
        end
        chk("done", 32'(done), 32'(1 << w));
        chk("err", 32'(err), ok_slv ? 32'(0) : 32'(1));
        chk("cs_low_cycles", 32'(lows), ok_slv ? 32'(8) : 32'(0));
        chk("cs_at_done", 32'(cs_n), CS_IDLE);
        chk("busy_gap", 32'(busy), 32'(1));
        if (ok_slv) begin
            rx_exp = sdata;
            chk("slave_rx", 32'(slv_rx[sidx]), 32'(mdata));
            chk("slave_bits", 32'(slv_cnt[sidx]), 32'(8));
        end
        chk("rx_data", 32'(rx_data), 32'(rx_exp));

        ptr = (w + 1) % NREQ;
        if (drop) req[w] = 1'b0;
        cyc();
        chk("done_pulse", 32'(done), 32'(0));
        chk("grant_clear", 32'(grant), 32'(0));
        chk("cs_between", 32'(cs_n), CS_IDLE);
        chk("err_pulse", 32'(err), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset    = 1'b1;
        req      = '0;
        req_slv  = '0;
        req_data = '0;
        for (int s = 0; s < NSLV; s++) slv_tx[s] = 8'($urandom);

        repeat (2) cyc();
        chk("rst_cs_n", 32'(cs_n), CS_IDLE);
        chk("rst_grant", 32'(grant), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_rx", 32'(rx_data), 32'(0));
        chk("rst_mosi", 32'(MOSI), 32'(0));
        reset = 1'b0;
        cyc();

        // Single transfer to slave 1.
        slv_tx[1]     = 8'h3C;
        req_slv[1:0]  = 2'd1;
        req_data[7:0] = 8'hA5;
        req[0]        = 1'b1;
        xfer(1'b1);

        // All requesters at once from a fresh pointer.
        reset = 1'b1;
        cyc();
        reset  = 1'b0;
        ptr    = 0;
        rx_exp = 8'h00;
        n      = int'($urandom);
        for (int i = 0; i < NREQ; i++) req_data[i*8 +: 8] = 8'(n + i * 37);
        req_slv = {2'd2, 2'd0, 2'd1, 2'd2};
        for (int s = 0; s < NSLV; s++) slv_tx[s] = 8'($urandom);
        req = 4'hF;
        repeat (4) xfer(1'b1);

        // Two requesters holding req continuously must alternate.
        req_slv  = 8'($urandom_range(0, 255)) & 8'b10_11_10_11;
        req_data = 32'($urandom);
        req      = 4'b1010;
        repeat (8) begin
            xfer(1'b0);
            req_data = 32'($urandom);
            for (int s = 0; s < NSLV; s++) slv_tx[s] = 8'($urandom);
        end
        req = '0;
        cyc();

        // Reset in the middle of a transfer.
        req_slv[5:4]    = 2'd2;
        req_data[23:16] = 8'($urandom);
        slv_tx[2]       = 8'($urandom);
        req             = 4'b0100;
        n = 0;
        while (grant == '0 && n < 12) begin
            cyc();
            n++;
        end
        chk("t4_grant", 32'(grant), 32'(4'b0100));
        repeat (4) cyc();
        chk("t4_cs_mid", 32'(cs_n), 32'(3'b011));
        reset = 1'b1;
        #1;
        chk("t4_cs_reset", 32'(cs_n), CS_IDLE);
        chk("t4_busy_reset", 32'(busy), 32'(0));
        chk("t4_grant_reset", 32'(grant), 32'(0));
        repeat (3) begin
            cyc();
            chk("t4_no_done", 32'(done), 32'(0));
        end
        chk("t4_rx_reset", 32'(rx_data), 32'(0));
        ptr             = 0;
        rx_exp          = 8'h00;
        req_data[23:16] = 8'h5A;
        slv_tx[2]       = 8'($urandom);
        reset           = 1'b0;
        xfer(1'b1);

        // Out-of-range slave index.
        req_slv[5:4] = 2'd3;
        req          = 4'b0100;
        xfer(1'b1);

        // Back-to-back to one slave; the second byte needs a fresh CS fall.
        req_slv[1:0]  = 2'd0;
        req_data[7:0] = 8'($urandom);
        slv_tx[0]     = 8'hF0;
        req           = 4'b0001;
        xfer(1'b0);
        slv_tx[0]     = 8'h0F;
        req_data[7:0] = 8'($urandom);
        xfer(1'b1);

        // Random request patterns, including the invalid slave index.
        repeat (8) begin
            req_slv  = 8'($urandom);
            req_data = 32'($urandom);
            for (int s = 0; s < NSLV; s++) slv_tx[s] = 8'($urandom);
            req = 4'($urandom_range(1, 15));
            xfer(1'b1);
            req = '0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
